// File: rtl/prng_sched_ctrl.sv
// prng_sched_ctrl: seeds an 8-bit dual-LFSR PRNG core, discards a warm-up run,
// then shares the core between NREQ requesters with round-robin arbitration,
// delivering one random byte per grant and reseeding automatically after a
// programmable number of bytes.
module prng_sched_ctrl #(
   parameter int NREQ            = 4,
   parameter int WARMUP_CYCLES   = 16,
   parameter int RESEED_INTERVAL = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic [7:0]      seed_in,
   input  logic            reseed,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic            rnd_valid,
   output logic [7:0]      rnd_data,
   output logic            core_load,
   output logic [7:0]      core_seed,
   output logic            core_step,
   input  logic [7:0]      core_data,
   output logic            ready
);

   localparam int          PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int          WW     = $clog2(WARMUP_CYCLES + 1);
   localparam int          CW_MIN = $clog2(RESEED_INTERVAL + 1);
   localparam int          CW     = (CW_MIN > 8) ? CW_MIN : 8;
   localparam int unsigned NREQ_U = NREQ;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEED,
      S_WARMUP,
      S_SERVE
   } state_t;

   state_t            state_q, state_nxt;
   logic [PW-1:0]     rr_q, rr_nxt;
   logic [WW-1:0]     warm_q, warm_nxt;
   logic [CW-1:0]     served_q, served_nxt, served_inc;
   logic [NREQ-1:0]   gnt_nxt;
   logic              valid_nxt;
   logic [7:0]        data_nxt;
   logic [7:0]        seed_nxt;
   logic              found;
   logic [PW-1:0]     win;
   logic              interval_hit;

   // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
   function automatic logic [7:0] fix_seed(input logic [7:0] s);
      return (s == 8'h00) ? 8'h01 : s;
   endfunction

   // Round-robin search: first requester at or after rr_q, wrapping.
   always_comb begin
      int unsigned   idx;
      logic [PW-1:0] idx_p;
      found = 1'b0;
      win   = '0;
      for (int unsigned i = 0; i < NREQ_U; i++) begin
         idx   = (32'(rr_q) + i) % NREQ_U;
         idx_p = PW'(idx);
         if (!found && req[idx_p]) begin
            found = 1'b1;
            win   = idx_p;
         end
      end
   end

   // Served-byte count saturates instead of wrapping when auto-reseed is off.
   always_comb begin
      served_inc   = (served_q == '1) ? served_q : served_q + 1'b1;
      interval_hit = (RESEED_INTERVAL > 0) && (served_inc == CW'(RESEED_INTERVAL));
   end

   // Next-state and core-control decode.
   always_comb begin
      state_nxt  = state_q;
      rr_nxt     = rr_q;
      warm_nxt   = warm_q;
      served_nxt = served_q;
      gnt_nxt    = '0;
      valid_nxt  = 1'b0;
      data_nxt   = rnd_data;
      seed_nxt   = core_seed;
      core_load  = 1'b0;
      core_step  = 1'b0;
      ready      = (state_q == S_SERVE);
      // The seed register is loaded on the edge entering SEED, so core_seed
      // is already valid during the single SEED cycle.
      if (ena) begin
         case (state_q)
            S_IDLE: begin
               state_nxt = S_SEED;
               seed_nxt  = fix_seed(seed_in);
            end
            S_SEED: begin
               core_load = 1'b1;
               state_nxt = S_WARMUP;
               warm_nxt  = '0;
            end
            S_WARMUP: begin
               if (reseed) begin
                  state_nxt  = S_SEED;
                  seed_nxt   = fix_seed(seed_in);
                  served_nxt = '0;
               end else begin
                  core_step = 1'b1;
                  if (warm_q == WW'(WARMUP_CYCLES - 1)) begin
                     state_nxt = S_SERVE;
                     warm_nxt  = '0;
                  end else begin
                     warm_nxt = warm_q + 1'b1;
                  end
               end
            end
            S_SERVE: begin
               if (reseed) begin
                  // User reseed wins over any pending request; fresh seed
                  // material restarts the byte budget.
                  state_nxt  = S_SEED;
                  seed_nxt   = fix_seed(seed_in);
                  served_nxt = '0;
               end else if (found) begin
                  core_step      = 1'b1;
                  gnt_nxt[win]   = 1'b1;
                  valid_nxt      = 1'b1;
                  data_nxt       = core_data;
                  rr_nxt         = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                  if (interval_hit) begin
                     state_nxt  = S_SEED;
                     served_nxt = '0;
                     seed_nxt   = fix_seed(seed_in ^ core_data);
                  end else begin
                     served_nxt = served_inc;
                  end
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         rr_q      <= '0;
         warm_q    <= '0;
         served_q  <= '0;
         gnt       <= '0;
         rnd_valid <= 1'b0;
         rnd_data  <= 8'h00;
         core_seed <= 8'h00;
      end else begin
         state_q   <= state_nxt;
         rr_q      <= rr_nxt;
         warm_q    <= warm_nxt;
         served_q  <= served_nxt;
         gnt       <= gnt_nxt;
         rnd_valid <= valid_nxt;
         rnd_data  <= data_nxt;
         core_seed <= seed_nxt;
      end
   end

endmodule

// File: tb/tb_prng_sched_ctrl.sv
// Scoreboard bench for prng_sched_ctrl: stimulus pushes expected grants and
// seeds into queues, monitors pop and compare when the DUT presents them.
module tb_prng_sched_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, rst_n_b, ena, reseed;
   logic [7:0] seed_in, core_data;
   logic [3:0] req_a, req_b;

   logic [3:0] gnt_a, gnt_b;
   logic       rnd_valid_a, rnd_valid_b, core_load_a, core_load_b;
   logic       core_step_a, core_step_b, ready_a, ready_b;
   logic [7:0] rnd_data_a, rnd_data_b, core_seed_a, core_seed_b;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] g;
      logic [7:0] d;
   } gexp_t;

   gexp_t      qa_g[$];
   gexp_t      qb_g[$];
   logic [7:0] qa_s[$];
   logic [7:0] qb_s[$];

   always #5 clk = ~clk;

   prng_sched_ctrl #(.NREQ(4), .WARMUP_CYCLES(4), .RESEED_INTERVAL(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .seed_in(seed_in), .reseed(reseed),
      .req(req_a), .gnt(gnt_a), .rnd_valid(rnd_valid_a), .rnd_data(rnd_data_a),
      .core_load(core_load_a), .core_seed(core_seed_a), .core_step(core_step_a),
      .core_data(core_data), .ready(ready_a)
   );

   prng_sched_ctrl #(.NREQ(4), .WARMUP_CYCLES(4), .RESEED_INTERVAL(3)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .ena(ena), .seed_in(seed_in), .reseed(reseed),
      .req(req_b), .gnt(gnt_b), .rnd_valid(rnd_valid_b), .rnd_data(rnd_data_b),
      .core_load(core_load_b), .core_seed(core_seed_b), .core_step(core_step_b),
      .core_data(core_data), .ready(ready_b)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready_a(input string nm);
      int n = 0;
      while (!ready_a && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(nm, int'(ready_a), 1);
   endtask

   // Monitor for instance A: grants and seed loads.
   always @(negedge clk) begin
      gexp_t e;
      if (rnd_valid_a) begin
         if (qa_g.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_grant unexpected gnt=%b data=%h expected none", gnt_a, rnd_data_a);
         end else begin
            e = qa_g.pop_front();
            chk("a_gnt", int'(gnt_a), int'(e.g));
            chk("a_data", int'(rnd_data_a), int'(e.d));
         end
      end else if (gnt_a != 4'b0000) begin
         checks++; errors++;
         $display("FAIL a_gnt_no_valid gnt=%b expected 0000", gnt_a);
      end
      if (core_load_a) begin
         if (qa_s.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_load unexpected seed=%h expected none", core_seed_a);
         end else begin
            chk("a_seed", int'(core_seed_a), int'(qa_s.pop_front()));
         end
      end
   end

   // Monitor for instance B.
   always @(negedge clk) begin
      gexp_t e;
      if (rnd_valid_b) begin
         if (qb_g.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_grant unexpected gnt=%b data=%h expected none", gnt_b, rnd_data_b);
         end else begin
            e = qb_g.pop_front();
            chk("b_gnt", int'(gnt_b), int'(e.g));
            chk("b_data", int'(rnd_data_b), int'(e.d));
         end
      end
      if (core_load_b) begin
         if (qb_s.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_load unexpected seed=%h expected none", core_seed_b);
         end else begin
            chk("b_seed", int'(core_seed_b), int'(qb_s.pop_front()));
         end
      end
   end

   // Directed stimulus.
   initial begin
      int loads, steps, first_rdy, frozen;
      rst_n = 1'b0; rst_n_b = 1'b0; ena = 1'b1; seed_in = 8'h5A;
      reseed = 1'b0; core_data = 8'h00; req_a = 4'h0; req_b = 4'h0;
      step();
      step();

      // Reset state.
      @(negedge clk);
      chk("rst_gnt",       int'(gnt_a), 0);
      chk("rst_valid",     int'(rnd_valid_a), 0);
      chk("rst_data",      int'(rnd_data_a), 0);
      chk("rst_core_seed", int'(core_seed_a), 0);
      chk("rst_load",      int'(core_load_a), 0);
      chk("rst_step",      int'(core_step_a), 0);
      chk("rst_ready",     int'(ready_a), 0);

      // Test 1: start-up sequence, WARMUP=4.
      qa_s.push_back(8'h5A);
      @(posedge clk); #1;
      rst_n = 1'b1;
      loads = 0; steps = 0; first_rdy = -1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         loads += int'(core_load_a);
         steps += int'(core_step_a);
         if (ready_a && first_rdy < 0) first_rdy = c;
      end
      chk("t1_loads", loads, 1);
      chk("t1_steps", steps, 4);
      chk("t1_ready_cycle", first_rdy, 6);

      // Test 2: all requesters held, round-robin order, pre-step data.
      step();
      for (int k = 0; k < 8; k++) begin
         req_a     = 4'hF;
         core_data = 8'h10 + 8'(k);
         qa_g.push_back('{g: 4'(1 << (k % 4)), d: 8'h10 + 8'(k)});
         step();
      end
      req_a = 4'h0;
      step();
      step();

      // Test 3: zero seed is replaced by 8'h01.
      seed_in = 8'h00;
      reseed  = 1'b1;
      qa_s.push_back(8'h01);
      step();
      reseed = 1'b0;
      wait_ready_a("t3_ready");
      step();

      // Test 4: reseed wins over a request; grant only after warm-up.
      seed_in = 8'h33;
      req_a   = 4'b0010;
      reseed  = 1'b1;
      qa_s.push_back(8'h33);
      step();
      reseed = 1'b0;
      repeat (5) step();
      core_data = 8'hB7;
      qa_g.push_back('{g: 4'b0010, d: 8'hB7});
      step();
      req_a = 4'h0;
      step();
      step();

      // Test 6: ena low for 5 cycles in the middle of warm-up.
      seed_in = 8'h77;
      reseed  = 1'b1;
      qa_s.push_back(8'h77);
      step();
      reseed = 1'b0;
      loads = 0; steps = 0; first_rdy = -1; frozen = 0;
      for (int c = 0; c < 16; c++) begin
         ena = !(c >= 3 && c < 8);
         @(negedge clk);
         loads += int'(core_load_a);
         steps += int'(core_step_a);
         if (!ena) frozen += int'(core_step_a | core_load_a | ready_a);
         if (ready_a && first_rdy < 0) first_rdy = c;
         @(posedge clk); #1;
      end
      ena = 1'b1;
      chk("t6_loads", loads, 1);
      chk("t6_steps", steps, 4);
      chk("t6_frozen_activity", frozen, 0);
      chk("t6_ready_cycle", first_rdy, 10);

      // Test 5: RESEED_INTERVAL=3 instance, auto-reseed with seed_in^core_data.
      seed_in = 8'hC3;
      rst_n_b = 1'b1;
      req_b   = 4'b0001;
      qb_s.push_back(8'hC3);
      qb_g.push_back('{g: 4'b0001, d: 8'h46});
      qb_g.push_back('{g: 4'b0001, d: 8'h47});
      qb_g.push_back('{g: 4'b0001, d: 8'h48});
      qb_s.push_back(8'hC3 ^ 8'h48);
      for (int c = 0; c < 13; c++) begin
         core_data = 8'h40 + 8'(c);
         if (c == 9) req_b = 4'h0;
         step();
      end
      repeat (3) step();

      chk("qa_grants_left", qa_g.size(), 0);
      chk("qa_seeds_left",  qa_s.size(), 0);
      chk("qb_grants_left", qb_g.size(), 0);
      chk("qb_seeds_left",  qb_s.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
